fftc_stage: RTL and testbench

- One parameterised stage of the 32-point radix-2 decimation-in-time FFT datapath.
- STAGE=0, 1 and 2 give the 2-, 4- and 8-point butterfly groups (the fftc0/fftc1/fftc2 roles). The top level instantiates 16, 8 and 4 copies of each stage, chained column to column.
- Each sample is a packed 16-bit complex word: real in bits [15:8], imaginary in bits [7:0], both signed two's complement.
- Results are registered: one clock of latency, with a valid flag.

---
 rtl/fftc_pkg.sv | 98 +++++++++
 rtl/fftc_bfly2.sv | 18 +
 rtl/fftc_stage.sv | 42 ++++
 tb/tb_fftc_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fftc_pkg.sv
// Shared complex word type and arithmetic helpers for the 32-point FFT columns.
// Define FFTC_SAT_EN to saturate adds, subtracts and twiddle narrowing.
package fftc_pkg;
  localparam int CW = 8;
  localparam int TW_C = 91;
  localparam int TW_SHIFT = 7;

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } cpx_t;

  function automatic logic signed [CW-1:0] fit(
    input logic signed [CW:0] v
  );
`ifdef FFTC_SAT_EN
    if (v > 9'sd127) return 8'sh7f;
    if (v < -9'sd128) return 8'sh80;
`endif
    return v[CW-1:0];
  endfunction

  function automatic logic signed [CW-1:0] narrow(
    input logic signed [2*CW:0] p
  );
    logic signed [2*CW:0] r;
    r = (p + 17'sd64) >>> TW_SHIFT;
`ifdef FFTC_SAT_EN
    if (r > 17'sd127) return 8'sh7f;
    if (r < -17'sd128) return 8'sh80;
`endif
    return r[CW-1:0];
  endfunction

  function automatic logic signed [2*CW:0] prod(
    input logic signed [CW:0] s
  );
    logic signed [2*CW:0] sx;
    logic signed [2*CW:0] c;
    sx = (2*CW+1)'(s);
    c = (2*CW+1)'(TW_C);
    return sx * c;
  endfunction

  function automatic logic signed [CW-1:0] neg(
    input logic signed [CW-1:0] v
  );
    logic signed [CW:0] w;
    w = (CW+1)'(v);
    return fit(-w);
  endfunction

  function automatic cpx_t cadd(input cpx_t x, input cpx_t y);
    cpx_t z;
    z.re = fit((CW+1)'(x.re) + (CW+1)'(y.re));
    z.im = fit((CW+1)'(x.im) + (CW+1)'(y.im));
    return z;
  endfunction

  function automatic cpx_t csub(input cpx_t x, input cpx_t y);
    cpx_t z;
    z.re = fit((CW+1)'(x.re) - (CW+1)'(y.re));
    z.im = fit((CW+1)'(x.im) - (CW+1)'(y.im));
    return z;
  endfunction

  // idx is scaled to an eighth-turn index so one table serves all N
  function automatic cpx_t cmul_tw(
    input cpx_t t,
    input int idx,
    input int n
  );
    cpx_t z;
    logic signed [CW:0] s;
    logic signed [CW:0] d;
    int e8;
    s = (CW+1)'(t.re) + (CW+1)'(t.im);
    d = (CW+1)'(t.im) - (CW+1)'(t.re);
    e8 = idx * (8 / n);
    z = t;
    case (e8)
      1: begin
        z.re = narrow(prod(s));
        z.im = narrow(prod(d));
      end
      2: begin
        z.re = t.im;
        z.im = neg(t.re);
      end
      3: begin
        z.re = narrow(prod(d));
        z.im = neg(narrow(prod(s)));
      end
      default: z = t;
    endcase
    return z;
  endfunction
endpackage

// File: rtl/fftc_bfly2.sv
// Combinational radix-2 butterfly with a fixed twiddle W_N^K.
module fftc_bfly2
  import fftc_pkg::*;
#(
  parameter int K = 0,
  parameter int N = 2
) (
  input  cpx_t xa,
  input  cpx_t xb,
  output cpx_t ya,
  output cpx_t yb
);
  cpx_t t;

  assign t  = cmul_tw(xb, K, N);
  assign ya = cadd(xa, t);
  assign yb = csub(xa, t);
endmodule

// File: rtl/fftc_stage.sv
// One registered FFT column: N/2 butterflies over an N-point group.
// Build option FFTC_SAT_EN selects saturating arithmetic.
module fftc_stage
  import fftc_pkg::*;
#(
  parameter int STAGE = 0,
  parameter int W = 8,
  localparam int N = 2 ** (STAGE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [N*2*W-1:0]   x_in,
  output logic               out_valid,
  output logic [N*2*W-1:0]   y_out
);
  localparam int H = N / 2;

  cpx_t [N-1:0] y_nxt;

  for (genvar k = 0; k < H; k++) begin : g_bf
    fftc_bfly2 #(
      .K(k),
      .N(N)
    ) u_bf (
      .xa(x_in[2*W*k +: 2*W]),
      .xb(x_in[2*W*(k+H) +: 2*W]),
      .ya(y_nxt[k]),
      .yb(y_nxt[k+H])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) y_out <= y_nxt;
    end
  end
endmodule

// File: tb/tb_fftc_stage.sv
// Scoreboard bench driving STAGE 0, 1 and 2 columns side by side.
module tb_fftc_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0]  x0 = '0;
  logic [63:0]  x1 = '0;
  logic [127:0] x2 = '0;
  logic [31:0]  y0;
  logic [63:0]  y1;
  logic [127:0] y2;
  logic ov0, ov1, ov2;

  int n_tests = 0;
  int n_fail = 0;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [127:0] q2[$];
  logic [127:0] e0 = '0;
  logic [127:0] e1 = '0;
  logic [127:0] e2 = '0;
  logic exp_v = 1'b0;
  logic last_rst = 1'b1;

  always #5 clk = ~clk;

  fftc_stage #(.STAGE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x_in(x0), .out_valid(ov0), .y_out(y0)
  );
  fftc_stage #(.STAGE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x_in(x1), .out_valid(ov1), .y_out(y1)
  );
  fftc_stage #(.STAGE(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x_in(x2), .out_valid(ov2), .y_out(y2)
  );

  task automatic chk(
    input string tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int fit(input int v);
`ifdef FFTC_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    logic signed [7:0] b;
    b = 8'(v);
    return int'(b);
`endif
  endfunction

  function automatic int rnd(input int v);
    return fit((v * 91 + 64) >>> 7);
  endfunction

  function automatic logic [127:0] model(input int st, input logic [127:0] x);
    logic [127:0] y;
    int n, h, e, a, b, ur, ui, tr, ti;
    n = 2 << st;
    h = n / 2;
    y = '0;
    for (int k = 0; k < h; k++) begin
      ur = $signed(x[16*k+8 +: 8]);
      ui = $signed(x[16*k +: 8]);
      a = $signed(x[16*(k+h)+8 +: 8]);
      b = $signed(x[16*(k+h) +: 8]);
      e = k * 8 / n;
      case (e)
        1: begin tr = rnd(a + b); ti = rnd(b - a); end
        2: begin tr = b; ti = fit(-a); end
        3: begin tr = rnd(b - a); ti = fit(-rnd(a + b)); end
        default: begin tr = a; ti = b; end
      endcase
      y[16*k+8 +: 8] = 8'(fit(ur + tr));
      y[16*k +: 8] = 8'(fit(ui + ti));
      y[16*(k+h)+8 +: 8] = 8'(fit(ur - tr));
      y[16*(k+h) +: 8] = 8'(fit(ui - ti));
    end
    return y;
  endfunction

  task automatic drive(
    input logic v, input logic r,
    input logic [127:0] a, input logic [127:0] b, input logic [127:0] c,
    input logic [127:0] ea, input logic [127:0] eb, input logic [127:0] ec
  );
    in_valid = v;
    rst = r;
    x0 = a[31:0];
    x1 = b[63:0];
    x2 = c;
    if (v && !r) begin
      q0.push_back(ea);
      q1.push_back(eb);
      q2.push_back(ec);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send_m(input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] c);
    drive(1'b1, 1'b0, a, b, c,
          model(0, {96'b0, a[31:0]}), model(1, {64'b0, b[63:0]}), model(2, c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  always @(posedge clk) begin
    exp_v <= in_valid && !rst;
    last_rst <= rst;
  end

  always @(negedge clk) begin
    chk("ov0", {127'b0, ov0}, {127'b0, exp_v});
    chk("ov1", {127'b0, ov1}, {127'b0, exp_v});
    chk("ov2", {127'b0, ov2}, {127'b0, exp_v});
    if (exp_v) begin
      if (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        e2 = q2.pop_front();
      end else begin
        chk("q_underflow", 128'd1, 128'd0);
      end
    end else if (last_rst) begin
      e0 = '0;
      e1 = '0;
      e2 = '0;
    end
    chk("y0", {96'b0, y0}, {96'b0, e0[31:0]});
    chk("y1", {64'b0, y1}, {64'b0, e1[63:0]});
    chk("y2", y2, e2);
  end

  initial begin
    logic [127:0] z;
    logic [127:0] ra, rb, rc;
    logic [127:0] ovf;
    z = '0;
`ifdef FFTC_SAT_EN
    ovf = {96'b0, 16'h7E00, 16'h7F00};
`else
    ovf = {96'b0, 16'h7E00, 16'h8000};
`endif
    drive(1'b0, 1'b1, z, z, z, z, z, z);
    drive(1'b0, 1'b1, z, z, z, z, z, z);
    idle(1);
    drive(1'b1, 1'b0, {96'b0, 16'h0300, 16'h0500}, z, z,
          {96'b0, 16'h0200, 16'h0800}, z, z);
    drive(1'b1, 1'b0, z, {64'b0, 16'h0400, 48'h0}, z,
          z, {64'b0, 16'h0004, 16'h0000, 16'h00FC, 16'h0000}, z);
    drive(1'b1, 1'b0, z, z, {32'b0, 16'h6400, 80'h0},
          z, z, {32'b0, 16'hB947, 48'h0, 16'h47B9, 16'h0000});
    idle(2);
    drive(1'b1, 1'b0, {96'b0, 16'h0100, 16'h7F00}, z, z, ovf, z, z);
    idle(3);
    drive(1'b1, 1'b1, {96'b0, 32'h11223344}, {64'b0, 64'h5566778899AABBCC},
          {128{1'b1}}, z, z, z);
    idle(2);
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = {$urandom, $urandom, $urandom, $urandom};
      if (i % 7 == 6) idle(1);
      else send_m(ra, rb, rc);
    end
    send_m({96'b0, 32'h80808080}, {64'b0, {4{16'h8080}}}, {8{16'h8080}});
    send_m({96'b0, 32'h7F7F7F7F}, {64'b0, {4{16'h7F7F}}}, {8{16'h7F7F}});
    idle(3);
    chk("q0_drain", 128'(q0.size()), 128'd0);
    chk("q1_drain", 128'(q1.size()), 128'd0);
    chk("q2_drain", 128'(q2.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
